// File: rtl/uart_tx.sv
// uart_tx: asynchronous-serial transmitter.
// Frame: start bit (0), DATA_W data bits LSB first, optional even-parity bit,
// stop bit (1). Every bit is held for CLK_DIV clocks, and tx comes straight
// from a flop, so the line never glitches.
//
// Handshake: a word transfers on a rising clk edge where tx_valid and tx_ready
// are both 1. tx_ready is high only in IDLE and out of reset. The source holds
// tx_valid until the transfer; a tx_valid seen while tx_ready is low is ignored.
module uart_tx #(
    parameter int CLK_DIV   = 16,
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div, div_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic              par, par_nxt;
    logic              tx_nxt;
    logic              div_last;

    assign tx_ready = (state == S_IDLE) && !rst;
    assign busy     = (state != S_IDLE);
    assign div_last = (div == DIV_LAST);

    // State and datapath registers; reset forces the line idle-high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            div     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nxt;
            div     <= div_nxt;
            bit_cnt <= bit_nxt;
            shift   <= shift_nxt;
            par     <= par_nxt;
            tx      <= tx_nxt;
        end
    end

    // Next-state logic: each bit lasts CLK_DIV clocks, then the next bit's
    // value is loaded into the tx flop on the same edge the state advances.
    always_comb begin
        state_nxt = state;
        div_nxt   = div;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        par_nxt   = par;
        tx_nxt    = tx;

        if (state != S_IDLE) begin
            div_nxt = div_last ? '0 : div + 1'b1;
        end

        case (state)
            S_IDLE: begin
                tx_nxt = 1'b1;
                if (tx_valid) begin
                    shift_nxt = tx_data;
                    par_nxt   = ^tx_data;
                    state_nxt = S_START;
                    tx_nxt    = 1'b0;
                    div_nxt   = '0;
                end
            end
            S_START: begin
                if (div_last) begin
                    state_nxt = S_DATA;
                    bit_nxt   = '0;
                    tx_nxt    = shift[0];
                    shift_nxt = shift >> 1;
                end
            end
            S_DATA: begin
                if (div_last) begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_nxt = '0;
                        if (PARITY_EN != 0) begin
                            state_nxt = S_PARITY;
                            tx_nxt    = par;
                        end else begin
                            state_nxt = S_STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_nxt   = bit_cnt + 1'b1;
                        tx_nxt    = shift[0];
                        shift_nxt = shift >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (div_last) begin
                    state_nxt = S_STOP;
                    tx_nxt    = 1'b1;
                end
            end
            S_STOP: begin
                if (div_last) begin
                    state_nxt = S_IDLE;
                    tx_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                div_nxt   = '0;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: bench for uart_tx with two instances sharing clk/rst:
// u0 without parity and u1 with even parity, both at CLK_DIV=4, DATA_W=8.
// Expected line waveforms come from a per-frame bit list built from the
// frame rules (start 0, data LSB first, parity = ones count mod 2, stop 1).
module tb_uart_tx;

    localparam int CD = 4;

    logic       clk;
    logic       rst;
    logic       tv  [2];
    logic [7:0] td  [2];
    logic       rd  [2];
    logic       txo [2];
    logic       bz  [2];

    int checks   = 0;
    int failures = 0;

    uart_tx #(.CLK_DIV(CD), .DATA_W(8), .PARITY_EN(0)) u0 (
        .clk(clk), .rst(rst), .tx_data(td[0]), .tx_valid(tv[0]),
        .tx_ready(rd[0]), .tx(txo[0]), .busy(bz[0])
    );

    uart_tx #(.CLK_DIV(CD), .DATA_W(8), .PARITY_EN(1)) u1 (
        .clk(clk), .rst(rst), .tx_data(td[1]), .tx_valid(tv[1]),
        .tx_ready(rd[1]), .tx(txo[1]), .busy(bz[1])
    );

    // Clock and run-time guard.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for tx_ready (bounded), present a word, and drop valid after the accepting edge.
    task automatic accept(input int k, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!rd[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(rd[k]), 32'd1);
        tv[k] = 1'b1;
        td[k] = d;
        @(posedge clk);
        #1;
        tv[k] = 1'b0;
        td[k] = 8'($urandom);
    endtask

    // Expected waveform after the accepting edge, then one idle cycle.
    task automatic check_frame(input int k, input logic [7:0] d);
        int bits[$];
        int ones;
        ones = 0;
        bits.push_back(0);
        for (int i = 0; i < 8; i++) begin
            bits.push_back((d >> i) & 1);
            ones += (d >> i) & 1;
        end
        if (k == 1) bits.push_back(ones % 2);
        bits.push_back(1);
        foreach (bits[j]) begin
            for (int c = 0; c < CD; c++) begin
                @(negedge clk);
                chk($sformatf("tx%0d_bit%0d", k, j), 32'(txo[k]), 32'(bits[j]));
                if (c == 0) begin
                    chk($sformatf("busy%0d_bit%0d", k, j), 32'(bz[k]), 32'd1);
                    chk($sformatf("ready%0d_bit%0d", k, j), 32'(rd[k]), 32'd0);
                end
            end
        end
        @(negedge clk);
        chk($sformatf("idle_tx%0d", k), 32'(txo[k]), 32'd1);
        chk($sformatf("idle_busy%0d", k), 32'(bz[k]), 32'd0);
        chk($sformatf("idle_ready%0d", k), 32'(rd[k]), 32'd1);
    endtask

    task automatic send(input int k, input logic [7:0] d);
        accept(k, d);
        check_frame(k, d);
    endtask

    task automatic quiet(input int k, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            chk($sformatf("quiet_tx%0d", k), 32'(txo[k]), 32'd1);
            chk($sformatf("quiet_busy%0d", k), 32'(bz[k]), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] w;
        rst = 1'b1;
        tv[0] = 1'b0; tv[1] = 1'b0;
        td[0] = 8'h00; td[1] = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx", 32'(txo[0]), 32'd1);
        chk("rst_busy", 32'(bz[0]), 32'd0);
        chk("rst_ready", 32'(rd[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ready0", 32'(rd[0]), 32'd1);
        chk("rel_ready1", 32'(rd[1]), 32'd1);

        // Directed frames: 0xA5 without parity, 0xA5/0x07 with parity.
        send(0, 8'hA5);
        send(1, 8'hA5);
        send(1, 8'h07);

        // Reset wins over a simultaneous tx_valid.
        @(negedge clk);
        rst = 1'b1;
        tv[0] = 1'b1;
        td[0] = 8'hFF;
        #1;
        chk("rstv_ready", 32'(rd[0]), 32'd0);
        chk("rstv_tx", 32'(txo[0]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tv[0] = 1'b0;
        #1;
        chk("rstv_busy", 32'(bz[0]), 32'd0);
        chk("rstv_ready_after", 32'(rd[0]), 32'd1);
        quiet(0, 2 * CD);

        // Back-to-back with valid held: 0x00 then 0xFF, data changed mid-frame.
        @(negedge clk);
        tv[0] = 1'b1;
        td[0] = 8'h00;
        @(posedge clk);
        #1;
        td[0] = 8'hFF;
        check_frame(0, 8'h00);
        @(posedge clk);
        #1;
        tv[0] = 1'b0;
        td[0] = 8'h3A;
        check_frame(0, 8'hFF);

        // Reset in the middle of data bit 3 of 0x55.
        accept(0, 8'h55);
        repeat (4 * CD + 1) @(negedge clk);
        chk("mid_bit3", 32'(txo[0]), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(txo[0]), 32'd1);
        chk("mid_rst_busy", 32'(bz[0]), 32'd0);
        chk("mid_rst_ready", 32'(rd[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", 32'(rd[0]), 32'd1);
        quiet(0, 3 * CD);
        send(0, 8'h3C);

        // Ignored tx_valid pulse while busy (parity instance).
        accept(1, 8'h96);
        fork
            check_frame(1, 8'h96);
            begin
                repeat (3 * CD) @(negedge clk);
                tv[1] = 1'b1;
                td[1] = 8'h5A;
                @(negedge clk);
                tv[1] = 1'b0;
            end
        join
        quiet(1, 3 * CD);

        // Random words through both instances.
        for (int n = 0; n < 6; n++) begin
            w = 8'($urandom_range(0, 255));
            send(0, w);
            w = 8'($urandom_range(0, 255));
            send(1, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Asynchronous-serial (UART-style) transmitter. Accepts one parallel word per valid/ready handshake and shifts it out on a single line: start bit, data LSB first, optional even parity, stop bit. It is the sending end of the board's serial link and is built from registered storage elements only. The serial output is glitch-free.

Parameters:
CLK_DIV, 16, clk cycles per serial bit; legal range >= 2
DATA_W, 8, data bits per frame; legal range 5..9
PARITY_EN, 0, 1 = insert even-parity bit after the data bits; 0 = no parity bit

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
tx_data  input  DATA_W  word to send; sampled only on handshake
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block can accept a word this cycle
tx  output  1  serial line; idle high; driven directly from a flop
busy  output  1  frame in progress, i.e. state != IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, tx=1, busy=0, bit counter=0, divider=0, shift register=0.
- tx_ready = (state==IDLE) && !rst. It is 0 throughout reset.
- States: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE.
- Handshake: a word is accepted at edge E0 when tx_valid=1 and tx_ready=1.
  - At E0: tx_data is latched into the shift register, even parity is computed (XOR of all bits), state -> START, tx -> 0, divider cleared.
  - tx_valid while tx_ready=0 is ignored. No queueing; the source holds tx_valid.
  - Changes to tx_data after E0 have no effect on the frame in flight.
- Bit timing: the divider counts 0..CLK_DIV-1. Each bit is held for exactly CLK_DIV cycles, measured from the edge that set it.
  - START: tx=0 for cycles E0+1 .. E0+CLK_DIV.
  - DATA bit i (i=0..DATA_W-1, LSB first): tx changes at edge E0+(1+i)*CLK_DIV.
  - PARITY (only if PARITY_EN=1): tx = even parity, so total ones over data+parity is even.
  - STOP: tx=1 for CLK_DIV cycles.
  - At the edge ending STOP: state -> IDLE and tx stays 1.
- Frame length: N = 2 + DATA_W + PARITY_EN bits = N*CLK_DIV cycles from E0 to the return to IDLE. The earliest next accept is one edge later, giving a minimum one-cycle idle gap between back-to-back frames.
- Bit counter: counts data bits 0..DATA_W-1. The wrap from DATA_W-1 leaves DATA without overflow.
- Shift register: right shift, tx takes the LSB. No combinational path from any input to tx.
- busy = 1 from E0+1 through the last STOP cycle, and 0 in IDLE.
- Reset mid-frame: tx -> 1 immediately (asynchronously), frame abandoned, state IDLE. tx_ready rises only after rst deasserts. No partial frame resumes.
- Simultaneous tx_valid and rst: reset wins; no word is accepted.
- A tx_valid held continuously sends consecutive frames, each separated by exactly 1 idle-high cycle.

Test Plan:
1. Reset: assert rst mid-simulation at an arbitrary time -> tx=1, busy=0, tx_ready=0 during rst; tx_ready=1 on the first cycle after release.
2. CLK_DIV=4, DATA_W=8, PARITY_EN=0, send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total). busy=1 for 40 cycles, then tx_ready=1.
3. PARITY_EN=1, send 0xA5 -> parity bit 0; send 0x07 -> parity bit 1. Frame = 11 bits = 44 cycles at CLK_DIV=4.
4. Back-to-back: tx_valid held high with 0x00 then 0xFF -> second start bit begins exactly 1 cycle after the first stop bit ends. tx_data changed mid-frame does not alter the first frame.
5. Reset mid-frame: rst pulse during data bit 3 of 0x55 -> tx goes to 1 within the same cycle, state IDLE. A new 0x3C sent afterwards is transmitted cleanly.
6. Ignored request: pulse tx_valid for 1 cycle during a busy frame -> no extra frame; the line returns idle after the current stop bit.
